// File: rtl/mont_pkg.sv
// Shared constants and type definitions for the Montgomery modular-exponentiation controller.
package mont_pkg;

  // Modulus and Montgomery constants for R = 2^64.
  localparam logic [63:0] N       = 64'hFFFF_FFFF_FFFF_FFF1;
  localparam logic [63:0] R2      = 64'h0000_0000_0000_00E1;
  localparam logic [63:0] ONE_BAR = 64'h0000_0000_0000_000F;

  typedef enum logic [2:0] {
    FLUSH,
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } ctrl_state_t;

  typedef enum logic [1:0] {
    CONV_IN,
    SQR,
    MUL,
    CONV_OUT
  } mont_op_t;

endpackage

// File: rtl/mont_modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving one shared montgomery_mul.
//
// state | meaning
// ------+---------------------------------------------------------------
// FLUSH | drain stale items from the unreset mul pipeline, then go IDLE
// IDLE  | ready_in=1, waiting for a request
// ISSUE | operands on mul_a/mul_b, waiting for mul_ready_in
// WAIT  | one op outstanding, waiting for mul_ready_out
// DONE  | result valid (ready_out=1) until given
module mont_modexp_ctrl
  import mont_pkg::*;
#(
  parameter int EXP_W        = 64,
  parameter int FLUSH_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [63:0]      base,
  input  logic [EXP_W-1:0] exp,
  input  logic             taken,
  output logic             ready_in,
  output logic [63:0]      result,
  output logic             ready_out,
  input  logic             given,
  output logic [63:0]      mul_a,
  output logic [63:0]      mul_b,
  output logic             mul_taken,
  input  logic             mul_ready_in,
  input  logic [63:0]      mul_out_bar,
  input  logic             mul_ready_out,
  output logic             mul_given,
  output logic             busy,
  output logic [15:0]      op_count
);

  localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
  localparam int FC_W  = $clog2(FLUSH_CYCLES + 1);

  ctrl_state_t      state_q, state_d;
  mont_op_t         op_q, op_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [63:0]      base_bar_q, base_bar_d;
  logic [63:0]      mul_a_q, mul_a_d;
  logic [63:0]      mul_b_q, mul_b_d;
  logic [63:0]      result_q, result_d;
  logic [15:0]      op_count_q, op_count_d;
  logic [FC_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic             next_bit;

  assign ready_in  = (state_q == IDLE);
  assign ready_out = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign mul_taken = (state_q == ISSUE) & mul_ready_in;
  assign mul_given = mul_ready_out & ((state_q == WAIT) | (state_q == FLUSH));
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign result    = result_q;
  assign op_count  = op_count_q;

  // Next-state and datapath decode; the accumulator lives in mul_a between ops.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    exp_d       = exp_q;
    idx_d       = idx_q;
    base_bar_d  = base_bar_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    result_d    = result_q;
    op_count_d  = op_count_q;
    flush_cnt_d = flush_cnt_q;
    next_bit    = 1'b0;
    case (state_q)
      FLUSH: begin
        if (flush_cnt_q == FC_W'(FLUSH_CYCLES - 1)) begin
          flush_cnt_d = '0;
          state_d     = IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end
      IDLE: begin
        if (taken) begin
          exp_d      = exp;
          op_d       = CONV_IN;
          mul_a_d    = base;
          mul_b_d    = R2;
          op_count_d = '0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (mul_taken) begin
          op_count_d = op_count_q + 16'd1;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (mul_given) begin
          case (op_q)
            CONV_IN: begin
              base_bar_d = mul_out_bar;
              idx_d      = IDX_W'(EXP_W - 1);
              op_d       = SQR;
              mul_a_d    = ONE_BAR;
              mul_b_d    = ONE_BAR;
            end
            SQR: begin
              if (exp_q[idx_q]) begin
                op_d    = MUL;
                mul_a_d = mul_out_bar;
                mul_b_d = base_bar_q;
              end else begin
                next_bit = 1'b1;
              end
            end
            MUL:      next_bit = 1'b1;
            CONV_OUT: result_d = mul_out_bar;
            default:  next_bit = 1'b0;
          endcase
          if (next_bit) begin
            if (idx_q == '0) begin
              op_d    = CONV_OUT;
              mul_a_d = mul_out_bar;
              mul_b_d = 64'd1;
            end else begin
              idx_d   = idx_q - 1'b1;
              op_d    = SQR;
              mul_a_d = mul_out_bar;
              mul_b_d = mul_out_bar;
            end
          end
          state_d = (op_q == CONV_OUT) ? DONE : ISSUE;
        end
      end
      DONE: begin
        if (given) state_d = IDLE;
      end
      default: state_d = FLUSH;
    endcase
  end

  // State registers; reset aborts any operation and restarts the pipeline flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FLUSH;
      op_q        <= CONV_IN;
      exp_q       <= '0;
      idx_q       <= '0;
      base_bar_q  <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      result_q    <= '0;
      op_count_q  <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      exp_q       <= exp_d;
      idx_q       <= idx_d;
      base_bar_q  <= base_bar_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      result_q    <= result_d;
      op_count_q  <= op_count_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_mont_modexp_ctrl.sv
// Directed bench for mont_modexp_ctrl with a behavioural random-latency Montgomery multiplier.
module tb_mont_modexp_ctrl;
  import mont_pkg::N;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] base = '0;
  logic [63:0] exp_v = '0;
  logic        taken = 1'b0;
  logic        given = 1'b0;
  logic        ready_in, ready_out, busy, mul_taken, mul_given;
  logic [63:0] result, mul_a, mul_b;
  logic [15:0] op_count;

  logic        mul_ready_in = 1'b1;
  logic        mul_ready_out = 1'b0;
  logic [63:0] mul_out_bar = '0;
  logic        mul_pend = 1'b0;
  int          mul_cnt = 0;
  logic [63:0] mul_val = '0;
  logic        stall_en = 1'b0;

  int checks = 0;
  int errors = 0;

  mont_modexp_ctrl #(.EXP_W(64), .FLUSH_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .base(base), .exp(exp_v), .taken(taken),
    .ready_in(ready_in), .result(result), .ready_out(ready_out), .given(given),
    .mul_a(mul_a), .mul_b(mul_b), .mul_taken(mul_taken), .mul_ready_in(mul_ready_in),
    .mul_out_bar(mul_out_bar), .mul_ready_out(mul_ready_out), .mul_given(mul_given),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Montgomery product a*b*R^-1 mod N via REDC, R = 2^64.
  function automatic logic [63:0] mont(input logic [63:0] a, input logic [63:0] b);
    logic [63:0]  inv, np, m;
    logic [127:0] t;
    logic [129:0] s;
    logic [65:0]  u;
    inv = 64'd1;
    repeat (7) inv = inv * (64'd2 - N * inv);
    np = -inv;
    t  = 128'(a) * 128'(b);
    m  = t[63:0] * np;
    s  = 130'(t) + 130'(m) * 130'(N);
    u  = s[129:64];
    return 64'(u % 66'(N));
  endfunction

  function automatic logic [63:0] mulmod(input logic [63:0] a, input logic [63:0] b);
    return 64'((128'(a) * 128'(b)) % 128'(N));
  endfunction

  function automatic logic [63:0] modexp_ref(input logic [63:0] b, input logic [63:0] e);
    logic [63:0] r, bb;
    bb = 64'(128'(b) % 128'(N));
    r  = 64'd1;
    for (int i = 63; i >= 0; i--) begin
      r = mulmod(r, r);
      if (e[i]) r = mulmod(r, bb);
    end
    return r;
  endfunction

  // Multiplier stand-in: no reset, one item in flight, random 1..4 cycle latency.
  always @(posedge clk) begin
    mul_ready_in <= stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    if (mul_ready_out && mul_given) mul_ready_out <= 1'b0;
    if (mul_taken) begin
      mul_pend <= 1'b1;
      mul_cnt  <= int'($urandom_range(0, 3));
      mul_val  <= mont(mul_a, mul_b);
    end else if (mul_pend) begin
      if (mul_cnt == 0) begin
        mul_ready_out <= 1'b1;
        mul_out_bar   <= mul_val;
        mul_pend      <= 1'b0;
      end else begin
        mul_cnt <= mul_cnt - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Advance one cycle and sample just after the edge; any presented mul result must be consumed.
  task automatic tick();
    @(posedge clk);
    #1;
    if (mul_ready_out) check("mul_given_protocol", 64'(mul_given), 64'd1);
  endtask

  task automatic run_req(input logic [63:0] b, input logic [63:0] e, input logic [63:0] want,
                         input int hold, input string tag);
    int n;
    logic [15:0] want_ops;
    want_ops = 16'(2 + 64 + $countones(e));
    n = 0;
    while (!ready_in && n < 200) begin tick(); n++; end
    check({tag, ":ready_in_wait"}, 64'(ready_in), 64'd1);
    base = b; exp_v = e; taken = 1'b1;
    tick();
    taken = 1'b0;
    check({tag, ":busy"}, 64'(busy), 64'd1);
    n = 0;
    while (!ready_out && n < 20000) begin tick(); n++; end
    check({tag, ":ready_out_wait"}, 64'(ready_out), 64'd1);
    check({tag, ":result"}, result, want);
    check({tag, ":op_count"}, 64'(op_count), 64'(want_ops));
    check({tag, ":ready_in_in_done"}, 64'(ready_in), 64'd0);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, ":hold_ready_out"}, 64'(ready_out), 64'd1);
      check({tag, ":hold_result"}, result, want);
      check({tag, ":hold_ready_in"}, 64'(ready_in), 64'd0);
    end
    given = 1'b1;
    tick();
    given = 1'b0;
    check({tag, ":ready_in_after_given"}, 64'(ready_in), 64'd1);
    check({tag, ":ready_out_after_given"}, 64'(ready_out), 64'd0);
  endtask

  initial begin
    logic [63:0] rb, re;
    int n;

    // Reset state
    repeat (3) tick();
    check("rst:ready_in", 64'(ready_in), 64'd0);
    check("rst:ready_out", 64'(ready_out), 64'd0);
    check("rst:busy", 64'(busy), 64'd1);
    check("rst:result", result, 64'd0);
    check("rst:mul_a", mul_a, 64'd0);
    check("rst:mul_b", mul_b, 64'd0);
    check("rst:mul_taken", 64'(mul_taken), 64'd0);
    check("rst:op_count", 64'(op_count), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      check("flush:ready_in", 64'(ready_in), 64'd0);
    end
    tick();
    check("flush:done", 64'(ready_in), 64'd1);

    // Directed vectors; the first one also holds DONE for 10 cycles
    run_req(64'd3, 64'd5, 64'd243, 10, "t1");
    run_req(64'd12345, 64'd0, 64'd1, 0, "t2a");
    run_req(64'd0, 64'd7, 64'd0, 0, "t2b");
    run_req(64'hFFFF_FFFF_FFFF_FFF0, 64'd2, 64'd1, 0, "t3a");
    run_req(64'hFFFF_FFFF_FFFF_FFF3, 64'd10, 64'd1024, 0, "t3b");

    // Same vectors with mul_ready_in stalls
    stall_en = 1'b1;
    run_req(64'd3, 64'd5, 64'd243, 0, "t4a");
    run_req(64'hFFFF_FFFF_FFFF_FFF3, 64'd10, 64'd1024, 0, "t4b");

    // Reset while an op is in flight, leaving a stale item in the multiplier
    stall_en = 1'b0;
    n = 0;
    while (!ready_in && n < 200) begin tick(); n++; end
    base = 64'd5; exp_v = 64'd3; taken = 1'b1;
    tick();
    taken = 1'b0;
    n = 0;
    while (!mul_pend && n < 200) begin tick(); n++; end
    check("t5:reached_wait", 64'(mul_pend), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5:ready_in", 64'(ready_in), 64'd0);
    check("t5:ready_out", 64'(ready_out), 64'd0);
    check("t5:busy", 64'(busy), 64'd1);
    check("t5:result", result, 64'd0);
    check("t5:mul_a", mul_a, 64'd0);
    check("t5:mul_taken", 64'(mul_taken), 64'd0);
    check("t5:op_count", 64'(op_count), 64'd0);
    tick();
    rst_n = 1'b1;
    n = 0;
    while (!ready_in && n < 200) begin tick(); n++; end
    check("t5:flush_ready_in", 64'(ready_in), 64'd1);
    check("t5:stale_drained", 64'({mul_pend, mul_ready_out}), 64'd0);
    run_req(64'd2, 64'd10, 64'd1024, 0, "t5b");

    // Back-to-back random requests against the plain modular-arithmetic model
    stall_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      rb = {32'($urandom), 32'($urandom)};
      re = {32'($urandom), 32'($urandom)};
      if (k % 4 == 1) rb = 64'($urandom_range(0, 20));
      if (k % 4 == 2) re = 64'($urandom_range(0, 300));
      if (k == 3) rb = N + 64'($urandom_range(0, 14));
      run_req(rb, re, modexp_ref(rb, re), 0, $sformatf("t6_%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
